// File: rtl/card_display_bank.sv
// card_display_bank: NUM_CH card slots, each decoded to a registered active-low 7-segment digit
// with per-slot blink blanking. Define CARD_DISPLAY_SCORE_EN to add the registered score output.
module card_display_bank #(
  parameter int NUM_CH    = 6,
  parameter int BLINK_DIV = 8
) (
  input  logic                      slow_clock,
  input  logic                      resetb,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_CH)-1:0] wr_addr,
  input  logic [3:0]                wr_card,
  input  logic                      clear_all,
  input  logic [NUM_CH-1:0]         blink_mask,
  output logic [7*NUM_CH-1:0]       hex_out,
`ifdef CARD_DISPLAY_SCORE_EN
  output logic [3:0]                score,
`endif
  output logic                      blink_phase
);

  localparam int AW = $clog2(NUM_CH);
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [NUM_CH-1:0][3:0]  card_q, card_d;
  logic [CW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [7*NUM_CH-1:0]     hex_q, hex_d;

  // Segment order is g f e d c b a (bit 6 .. bit 0), active-low.
  function automatic logic [6:0] decode_card(input logic [3:0] card);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (card)
      4'd1:    seg = 7'b0001000;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      4'd10:   seg = 7'b1000000;
      4'd11:   seg = 7'b1100001;
      4'd12:   seg = 7'b0011000;
      4'd13:   seg = 7'b0001001;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Write port: a single-cycle strobe, no backpressure. wr_en with a valid wr_addr
  // loads the slot on that edge; out-of-range addresses match no slot and are dropped.
  always_comb begin
    card_d = card_q;
    if (clear_all) begin
      card_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == AW'(i)) begin
          card_d[i] = wr_card;
        end
      end
    end
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Blanking uses the registered phase, so it lines up with the card registers.
  always_comb begin
    hex_d = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (blink_mask[i] && !blink_phase_q) begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end else begin
        hex_d[7*i +: 7] = decode_card(card_q[i]);
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      card_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      hex_q         <= '1;
    end else begin
      card_q        <= card_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hex_q         <= hex_d;
    end
  end

  assign hex_out     = hex_q;
  assign blink_phase = blink_phase_q;

`ifdef CARD_DISPLAY_SCORE_EN
  localparam int SW = $clog2(9 * NUM_CH + 1);

  logic [SW-1:0] pip_sum;
  logic [3:0]    score_q, score_d;

  function automatic logic [3:0] pip_value(input logic [3:0] card);
    return ((card >= 4'd1) && (card <= 4'd9)) ? card : 4'd0;
  endfunction

  always_comb begin
    pip_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pip_sum = pip_sum + SW'(pip_value(card_q[i]));
    end
    score_d = 4'(pip_sum % SW'(10));
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_card_display_bank.sv
// Directed bench for card_display_bank: driver pushes hand-computed {score, hex} targets
// tagged with the cycle they must appear on; a negedge monitor pops and compares.
module tb_card_display_bank;

  localparam int NUM_CH    = 6;
  localparam int BLINK_DIV = 8;
  localparam int HW        = 7 * NUM_CH;
  localparam int W         = HW + 4;

  localparam logic [6:0] S_BL = 7'b1111111;

  logic              clk;
  logic              resetb;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [3:0]        wr_card;
  logic              clear_all;
  logic [NUM_CH-1:0] blink_mask;
  logic [HW-1:0]     hex_out;
  logic              blink_phase;
`ifdef CARD_DISPLAY_SCORE_EN
  logic [3:0]        score;
`endif

  card_display_bank #(.NUM_CH(NUM_CH), .BLINK_DIV(BLINK_DIV)) dut (
    .slow_clock  (clk),
    .resetb      (resetb),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_card     (wr_card),
    .clear_all   (clear_all),
    .blink_mask  (blink_mask),
    .hex_out     (hex_out),
`ifdef CARD_DISPLAY_SCORE_EN
    .score       (score),
`endif
    .blink_phase (blink_phase)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk or negedge resetb) begin
    if (!resetb) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           assert_cnt = 0;
  int           fail_cnt   = 0;
  logic [HW-1:0] exp_hex;

  function automatic logic phase_at(input int c);
    return ((c / BLINK_DIV) % 2) == 0;
  endfunction

  function automatic logic [HW-1:0] put(input logic [HW-1:0] v, input int s, input logic [6:0] p);
    logic [HW-1:0] r;
    r = v;
    r[7*s +: 7] = p;
    return r;
  endfunction

  task automatic expect_at(input int c, input logic [HW-1:0] h, input logic [3:0] sc);
    exp_cyc_q.push_back(c);
    exp_q.push_back({sc, h});
  endtask

  always @(negedge clk) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      int           tc;
      logic [W-1:0] e;
      logic         ph;
      tc = exp_cyc_q.pop_front();
      e  = exp_q.pop_front();
      if (tc < cyc) begin
        assert_cnt++;
        fail_cnt++;
        $display("FAIL missed_check target=%0d now=%0d", tc, cyc);
      end else begin
        assert_cnt++;
        if (hex_out !== e[HW-1:0]) begin
          fail_cnt++;
          $display("FAIL hex_out cyc=%0d got=%b exp=%b", cyc, hex_out, e[HW-1:0]);
        end
        ph = resetb ? phase_at(cyc) : 1'b1;
        assert_cnt++;
        if (blink_phase !== ph) begin
          fail_cnt++;
          $display("FAIL blink_phase cyc=%0d got=%b exp=%b", cyc, blink_phase, ph);
        end
`ifdef CARD_DISPLAY_SCORE_EN
        assert_cnt++;
        if (score !== e[W-1:HW]) begin
          fail_cnt++;
          $display("FAIL score cyc=%0d got=%0d exp=%0d", cyc, score, e[W-1:HW]);
        end
`endif
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_card(input logic [2:0] a, input logic [3:0] c, input logic [6:0] p, input logic [3:0] sc);
    int t;
    t = cyc;
    if (a < 3'(NUM_CH)) exp_hex = put(exp_hex, int'(a), p);
    expect_at(t + 2, exp_hex, sc);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_card = c;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      assert_cnt++;
      fail_cnt++;
      $display("FAIL drain_timeout pending=%0d", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  initial begin
    int t;
    resetb     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_card    = '0;
    clear_all  = 1'b0;
    blink_mask = '0;
    exp_hex    = '1;
    expect_at(0, '1, 4'd0);
    #22;
    resetb = 1'b1;

    // reset then idle
    for (int c = 1; c <= 3; c++) expect_at(c, '1, 4'd0);
    repeat (3) tick();

    // basic writes
    write_card(3'd0, 4'd1,  7'b0001000, 4'd1);
    write_card(3'd1, 4'd10, 7'b1000000, 4'd1);
    write_card(3'd5, 4'd13, 7'b0001001, 4'd1);
    tick();

    // clear_all beats a same-cycle write
    t = cyc;
    exp_hex = '1;
    expect_at(t + 2, exp_hex, 4'd0);
    expect_at(t + 3, exp_hex, 4'd0);
    clear_all = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 3'd2;
    wr_card   = 4'd7;
    tick();
    clear_all = 1'b0;
    wr_en     = 1'b0;
    tick();

    // remaining decode codes
    write_card(3'd0, 4'd2,  7'b0100100, 4'd2);
    write_card(3'd1, 4'd4,  7'b0011001, 4'd6);
    write_card(3'd2, 4'd6,  7'b0000010, 4'd2);
    write_card(3'd3, 4'd11, 7'b1100001, 4'd2);
    write_card(3'd4, 4'd12, 7'b0011000, 4'd2);
    write_card(3'd5, 4'd14, S_BL,       4'd2);

    // out-of-range address is dropped
    write_card(3'd7, 4'd5, S_BL, 4'd2);
    expect_at(cyc + 2, exp_hex, 4'd2);
    tick();

    // blink on slot 3
    write_card(3'd3, 4'd8, 7'b0000000, 4'd0);
    blink_mask = 6'b001000;
    t = cyc;
    for (int c = t + 1; c <= t + 20; c++)
      expect_at(c, put(exp_hex, 3, phase_at(c - 1) ? 7'b0000000 : S_BL), 4'd0);
    repeat (20) tick();
    for (int i = 0; i < 2 * BLINK_DIV + 2 && phase_at(cyc - 1); i++) tick();
    expect_at(cyc, put(exp_hex, 3, S_BL), 4'd0);
    expect_at(cyc + 1, exp_hex, 4'd0);
    expect_at(cyc + 2, exp_hex, 4'd0);
    blink_mask = '0;
    tick();
    wait_drain();

    // score sequence
    write_card(3'd0, 4'd9,  7'b0010000, 4'd7);
    write_card(3'd1, 4'd7,  7'b1111000, 4'd0);
    write_card(3'd2, 4'd13, 7'b0001001, 4'd4);
    write_card(3'd3, 4'd5,  7'b0010010, 4'd1);
    write_card(3'd4, 4'd0,  S_BL,       4'd1);
    write_card(3'd5, 4'd3,  7'b0110000, 4'd4);
    write_card(3'd0, 4'd10, 7'b1000000, 4'd5);
    wait_drain();

    // reset mid-run returns everything to reset values and restarts the counter
    blink_mask = 6'b111111;
    #3;
    resetb  = 1'b0;
    exp_hex = '1;
    expect_at(0, '1, 4'd0);
    #20;
    blink_mask = '0;
    resetb = 1'b1;
    for (int c = 1; c <= 10; c++) expect_at(c, '1, 4'd0);
    wait_drain();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
